// File: rtl/player_speed_controller.sv
// Per-frame speed profile for the player car: throttle/brake/coast, crash spin-out and finish run-down.
// All state advances only on startOfFrame; outputs are registered and hold between frame pulses.
module player_speed_controller #(
    parameter int unsigned MAX_SPEED    = 640,
    parameter int unsigned ACCEL_STEP   = 4,
    parameter int unsigned BRAKE_STEP   = 12,
    parameter int unsigned COAST_STEP   = 1,
    parameter int unsigned CRASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       throttle,
    input  logic       brake,
    input  logic       collision,
    input  logic       race_done,
    output logic [9:0] player_speed,
    output logic       crashed,
    output logic       finished
);

    localparam int unsigned TW = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

    localparam logic [10:0]   MAX_W      = 11'(MAX_SPEED);
    localparam logic [10:0]   ACCEL_W    = 11'(ACCEL_STEP);
    localparam logic [10:0]   BRAKE_W    = 11'(BRAKE_STEP);
    localparam logic [10:0]   COAST_W    = 11'(COAST_STEP);
    localparam logic [TW-1:0] TIMER_INIT = TW'(CRASH_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_DRIVING  = 2'd0,
        ST_CRASHED  = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [9:0]    speed_q,    speed_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic          coll_q,     coll_d;
    logic          crashed_q,  crashed_d;
    logic          finished_q, finished_d;
    logic          coll_seen;

    // 11-bit headroom keeps the sum exact before clamping to the ceiling.
    function automatic logic [9:0] sat_add(input logic [9:0] v, input logic [10:0] step);
        logic [10:0] sum;
        sum = {1'b0, v} + step;
        if (sum > MAX_W) begin
            return MAX_W[9:0];
        end
        return sum[9:0];
    endfunction

    // A borrow out of the 11-bit difference means the result went below zero.
    function automatic logic [9:0] sat_sub(input logic [9:0] v, input logic [10:0] step);
        logic [10:0] diff;
        diff = {1'b0, v} - step;
        if (diff[10]) begin
            return 10'd0;
        end
        if (diff > MAX_W) begin
            return MAX_W[9:0];
        end
        return diff[9:0];
    endfunction

    assign coll_seen = coll_q | collision;

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        timer_d = timer_q;
        coll_d  = coll_seen;

        if (startOfFrame) begin
            coll_d = 1'b0;
            unique case (state_q)
                ST_DRIVING: begin
                    if (race_done) begin
                        state_d = ST_FINISHED;
                        speed_d = sat_sub(speed_q, BRAKE_W);
                    end else if (coll_seen) begin
                        state_d = ST_CRASHED;
                        speed_d = 10'd0;
                        timer_d = TIMER_INIT;
                    end else if (brake) begin
                        speed_d = sat_sub(speed_q, BRAKE_W);
                    end else if (throttle) begin
                        speed_d = sat_add(speed_q, ACCEL_W);
                    end else begin
                        speed_d = sat_sub(speed_q, COAST_W);
                    end
                end
                ST_CRASHED: begin
                    speed_d = 10'd0;
                    if (race_done) begin
                        state_d = ST_FINISHED;
                    end else if (timer_q == '0) begin
                        state_d = ST_DRIVING;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                ST_FINISHED: begin
                    speed_d = sat_sub(speed_q, BRAKE_W);
                end
                default: begin
                    state_d = ST_DRIVING;
                    speed_d = 10'd0;
                end
            endcase
        end

        crashed_d  = (state_d == ST_CRASHED);
        finished_d = (state_d == ST_FINISHED);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_DRIVING;
            speed_q    <= 10'd0;
            timer_q    <= '0;
            coll_q     <= 1'b0;
            crashed_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            timer_q    <= timer_d;
            coll_q     <= coll_d;
            crashed_q  <= crashed_d;
            finished_q <= finished_d;
        end
    end

    assign player_speed = speed_q;
    assign crashed      = crashed_q;
    assign finished     = finished_q;

endmodule

// File: tb/tb_player_speed_controller.sv
// Scoreboard bench for player_speed_controller: stimulus pushes expected per-frame results,
// a negedge monitor pops them after each frame pulse and checks that outputs hold in between.
module tb_player_speed_controller;

    localparam int MAXS = 640;
    localparam int ACC  = 4;
    localparam int BRK  = 12;
    localparam int CST  = 1;
    localparam int CRF  = 60;
    localparam int GAP  = 5;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       throttle = 1'b0;
    logic       brake = 1'b0;
    logic       collision = 1'b0;
    logic       race_done = 1'b0;
    logic [9:0] player_speed;
    logic       crashed;
    logic       finished;

    player_speed_controller #(
        .MAX_SPEED   (MAXS),
        .ACCEL_STEP  (ACC),
        .BRAKE_STEP  (BRK),
        .COAST_STEP  (CST),
        .CRASH_FRAMES(CRF)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .throttle    (throttle),
        .brake       (brake),
        .collision   (collision),
        .race_done   (race_done),
        .player_speed(player_speed),
        .crashed     (crashed),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] spd;
        logic       cr;
        logic       fin;
    } exp_t;

    typedef enum {DRV, CRS, FIN} mstate_t;

    exp_t    q[$];
    exp_t    held = '0;
    int      errors = 0;
    int      checks = 0;
    bit      sof_prev = 1'b0;

    mstate_t m_state = DRV;
    int      m_speed = 0;
    int      m_left  = 0;
    bit      m_coll  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) sof_prev <= startOfFrame && resetN;

    always @(negedge clk) begin
        if (!resetN) begin
            held = '0;
        end else if (sof_prev) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got frame update with no expectation at %0t", $time);
            end else begin
                held = q.pop_front();
            end
        end
        check("speed", player_speed, held.spd);
        check("crashed", crashed, held.cr);
        check("finished", finished, held.fin);
    end

    function automatic int down(input int v, input int step);
        return (v > step) ? v - step : 0;
    endfunction

    function automatic void model_step(input bit thr, input bit brk, input bit rd, input bit seen);
        case (m_state)
            FIN: m_speed = down(m_speed, BRK);
            CRS: begin
                m_speed = 0;
                if (rd) begin
                    m_state = FIN;
                end else begin
                    m_left--;
                    if (m_left == 0) m_state = DRV;
                end
            end
            default: begin
                if (rd) begin
                    m_state = FIN;
                    m_speed = down(m_speed, BRK);
                end else if (seen) begin
                    m_state = CRS;
                    m_speed = 0;
                    m_left  = CRF;
                end else if (brk) begin
                    m_speed = down(m_speed, BRK);
                end else if (thr) begin
                    m_speed = (m_speed + ACC > MAXS) ? MAXS : m_speed + ACC;
                end else begin
                    m_speed = down(m_speed, CST);
                end
            end
        endcase
    endfunction

    task automatic cyc(input bit sof, input bit col);
        @(negedge clk);
        #1;
        startOfFrame = sof;
        collision    = col;
        if (col) m_coll = 1'b1;
    endtask

    // cpos: clocks before the frame pulse at which collision fires (0 = coincident, <0 = none)
    task automatic frame(input bit thr, input bit brk, input bit rd, input int cpos);
        exp_t e;
        for (int k = GAP - 1; k >= 1; k--) begin
            cyc(1'b0, cpos == k);
            if (k == GAP - 1) begin
                throttle  = thr;
                brake     = brk;
                race_done = rd;
            end
        end
        cyc(1'b1, cpos == 0);
        model_step(thr, brk, rd, m_coll);
        m_coll = 1'b0;
        e.spd = 10'(m_speed);
        e.cr  = (m_state == CRS);
        e.fin = (m_state == FIN);
        q.push_back(e);
    endtask

    task automatic frames(input int n, input bit thr, input bit brk, input bit rd);
        for (int i = 0; i < n; i++) frame(thr, brk, rd, -1);
    endtask

    task automatic async_reset(input bit check_now);
        cyc(1'b0, 1'b0);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        if (check_now) begin
            check("rst_speed", player_speed, 0);
            check("rst_crashed", crashed, 0);
            check("rst_finished", finished, 0);
        end
        throttle  = 1'b0;
        brake     = 1'b0;
        race_done = 1'b0;
        m_state = DRV;
        m_speed = 0;
        m_left  = 0;
        m_coll  = 1'b0;
        q.delete();
        @(posedge clk);
        #2;
        resetN = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        resetN = 1'b1;

        frames(200, 1'b1, 1'b0, 1'b0);
        frames(10, 1'b1, 1'b1, 1'b0);
        frames(5, 1'b0, 1'b0, 1'b0);

        frames(35, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < CRF; i++) frame(1'b1, 1'b0, 1'b0, (i == 29) ? 2 : -1);
        frame(1'b1, 1'b0, 1'b0, -1);

        frames(50, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 0);
        frames(CRF, 1'b0, 1'b0, 1'b0);

        frames(8, 1'b1, 1'b0, 1'b0);
        frames(2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 1'b1, 1);

        async_reset(1'b1);
        frames(5, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0, 2);
        frames(10, 1'b1, 1'b0, 1'b0);
        async_reset(1'b1);
        frame(1'b1, 1'b0, 1'b0, -1);
        frame(1'b1, 1'b0, 1'b0, 1);
        frames(5, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b1, -1);
        frames(3, 1'b1, 1'b0, 1'b1);

        async_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            int  cp;
            bit  thr, brk, rd;
            thr = ($urandom_range(0, 3) != 0);
            brk = ($urandom_range(0, 4) == 0);
            rd  = (i > 300) && ($urandom_range(0, 19) == 0);
            cp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, GAP - 1)) : -1;
            frame(thr, brk, rd, cp);
        end

        cyc(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
